// File: rtl/ctrl_decode_stage.sv
// Registered RV32I decode/control stage (IF/ID -> ID/EX) with load-use stall, flush and backpressure.
// Optional illegal-instruction trapping is enabled by defining CTRL_ILLEGAL_TRAP_EN.
module ctrl_decode_stage #(
  parameter int DWIDTH   = 32,
  parameter int ALUSEL_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DWIDTH-1:0]   insn_i,
  input  logic [DWIDTH-1:0]   pc_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [DWIDTH-1:0]   pc_o,
  output logic [DWIDTH-1:0]   insn_o,
  output logic [4:0]          rd_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic                pcsel_o,
  output logic                immsel_o,
  output logic                regwren_o,
  output logic                rs1sel_o,
  output logic                rs2sel_o,
  output logic                memren_o,
  output logic                memwren_o,
  output logic [1:0]          wbsel_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic                illegal_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;
  localparam logic [1:0] WBSEL_IMM = 2'd3;

  localparam logic [ALUSEL_W-1:0] ALU_OP_ADD  = ALUSEL_W'(4'd0);
  localparam logic [ALUSEL_W-1:0] ALU_OP_SUB  = ALUSEL_W'(4'd1);
  localparam logic [ALUSEL_W-1:0] ALU_OP_SLL  = ALUSEL_W'(4'd2);
  localparam logic [ALUSEL_W-1:0] ALU_OP_SLT  = ALUSEL_W'(4'd3);
  localparam logic [ALUSEL_W-1:0] ALU_OP_SLTU = ALUSEL_W'(4'd4);
  localparam logic [ALUSEL_W-1:0] ALU_OP_XOR  = ALUSEL_W'(4'd5);
  localparam logic [ALUSEL_W-1:0] ALU_OP_SRL  = ALUSEL_W'(4'd6);
  localparam logic [ALUSEL_W-1:0] ALU_OP_SRA  = ALUSEL_W'(4'd7);
  localparam logic [ALUSEL_W-1:0] ALU_OP_OR   = ALUSEL_W'(4'd8);
  localparam logic [ALUSEL_W-1:0] ALU_OP_AND  = ALUSEL_W'(4'd9);

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // alt selects SUB (register form only) and SRA
  function automatic logic [ALUSEL_W-1:0] alu_op(input logic [2:0] funct3, input logic alt,
                                                 input logic is_imm);
    case (funct3)
      3'b000:  alu_op = (alt && !is_imm) ? ALU_OP_SUB : ALU_OP_ADD;
      3'b001:  alu_op = ALU_OP_SLL;
      3'b010:  alu_op = ALU_OP_SLT;
      3'b011:  alu_op = ALU_OP_SLTU;
      3'b100:  alu_op = ALU_OP_XOR;
      3'b101:  alu_op = alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'b110:  alu_op = ALU_OP_OR;
      3'b111:  alu_op = ALU_OP_AND;
      default: alu_op = ALU_OP_ADD;
    endcase
  endfunction

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd, w_rs1, w_rs2;

  assign w_opcode = insn_i[6:0];
  assign w_rd     = insn_i[11:7];
  assign w_funct3 = insn_i[14:12];
  assign w_rs1    = insn_i[19:15];
  assign w_rs2    = insn_i[24:20];
  assign w_funct7 = insn_i[31:25];

  logic                w_pcsel, w_immsel, w_regwren, w_rs1sel, w_rs2sel, w_memren, w_memwren;
  logic [1:0]          w_wbsel;
  logic [ALUSEL_W-1:0] w_alusel;
  logic                w_illegal, w_uses_rs1, w_uses_rs2;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic w_bad;

  always_comb begin
    w_bad = 1'b0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: w_bad = 1'b0;
      OPC_JALR:   w_bad = (w_funct3 != 3'b000);
      OPC_BRANCH: w_bad = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      OPC_LOAD:   w_bad = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
      OPC_STORE:  w_bad = (w_funct3 >= 3'b011);
      OPC_OP_IMM: w_bad = ((w_funct3 == 3'b001) && (w_funct7 != F7_ZERO)) ||
                          ((w_funct3 == 3'b101) && (w_funct7 != F7_ZERO) && (w_funct7 != F7_ALT));
      OPC_OP:     w_bad = (w_funct7 != F7_ZERO) &&
                          !((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
      default:    w_bad = 1'b1;
    endcase
  end
`endif

  // Combinational decode of the incoming instruction; anything unrecognised is a NOP
  always_comb begin
    w_pcsel    = 1'b0;
    w_immsel   = 1'b0;
    w_regwren  = 1'b0;
    w_rs1sel   = 1'b0;
    w_rs2sel   = 1'b0;
    w_memren   = 1'b0;
    w_memwren  = 1'b0;
    w_wbsel    = WBSEL_ALU;
    w_alusel   = ALU_OP_ADD;
    w_illegal  = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_regwren = 1'b1; w_immsel = 1'b1; w_wbsel = WBSEL_IMM;
      end
      OPC_AUIPC: begin
        w_regwren = 1'b1; w_immsel = 1'b1;
      end
      OPC_JAL: begin
        w_regwren = 1'b1; w_pcsel = 1'b1; w_immsel = 1'b1; w_wbsel = WBSEL_PC4;
      end
      OPC_JALR: begin
        w_regwren = 1'b1; w_pcsel = 1'b1; w_immsel = 1'b1; w_rs1sel = 1'b1;
        w_wbsel = WBSEL_PC4; w_uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        w_pcsel = 1'b1; w_immsel = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        w_regwren = 1'b1; w_immsel = 1'b1; w_rs1sel = 1'b1; w_memren = 1'b1;
        w_wbsel = WBSEL_MEM; w_uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        w_memwren = 1'b1; w_immsel = 1'b1; w_rs1sel = 1'b1;
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        w_regwren = 1'b1; w_immsel = 1'b1; w_rs1sel = 1'b1; w_uses_rs1 = 1'b1;
        w_alusel = alu_op(w_funct3, insn_i[30], 1'b1);
      end
      OPC_OP: begin
        w_regwren = 1'b1; w_rs1sel = 1'b1; w_rs2sel = 1'b1;
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
        w_alusel = alu_op(w_funct3, (w_funct7 == F7_ALT), 1'b0);
      end
      default: begin
        w_regwren = 1'b0;
      end
    endcase
    if (w_rd == 5'd0) begin
      w_regwren = 1'b0;
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (w_bad) begin
      w_illegal = 1'b1;
      w_regwren = 1'b0;
      w_memren  = 1'b0;
      w_memwren = 1'b0;
      w_pcsel   = 1'b0;
    end
`endif
  end

  logic                r_valid;
  logic [DWIDTH-1:0]   r_pc, r_insn;
  logic [4:0]          r_rd, r_rs1, r_rs2;
  logic                r_pcsel, r_immsel, r_regwren, r_rs1sel, r_rs2sel, r_memren, r_memwren;
  logic [1:0]          r_wbsel;
  logic [ALUSEL_W-1:0] r_alusel;
  logic                r_illegal;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic w_hazard, w_in_ready, w_accept;

  assign w_hazard = r_valid && r_memren && (r_rd != 5'd0) && in_valid_i &&
                    ((w_uses_rs1 && (w_rs1 == r_rd)) || (w_uses_rs2 && (w_rs2 == r_rd)));
  assign w_in_ready = flush_i || (!w_hazard && (!r_valid || out_ready_i));
  assign w_accept   = in_valid_i && w_in_ready && !flush_i;

  // ID/EX register: flush > hazard > accept > drain > hold; invalid entries carry no enables
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_insn    <= '0;
      r_rd      <= 5'd0;
      r_rs1     <= 5'd0;
      r_rs2     <= 5'd0;
      r_pcsel   <= 1'b0;
      r_immsel  <= 1'b0;
      r_regwren <= 1'b0;
      r_rs1sel  <= 1'b0;
      r_rs2sel  <= 1'b0;
      r_memren  <= 1'b0;
      r_memwren <= 1'b0;
      r_wbsel   <= WBSEL_ALU;
      r_alusel  <= ALU_OP_ADD;
      r_illegal <= 1'b0;
    end else if (flush_i || (out_ready_i && (w_hazard || !w_accept))) begin
      r_valid   <= 1'b0;
      r_pcsel   <= 1'b0;
      r_regwren <= 1'b0;
      r_memren  <= 1'b0;
      r_memwren <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_pc      <= pc_i;
      r_insn    <= insn_i;
      r_rd      <= w_rd;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_pcsel   <= w_pcsel;
      r_immsel  <= w_immsel;
      r_regwren <= w_regwren;
      r_rs1sel  <= w_rs1sel;
      r_rs2sel  <= w_rs2sel;
      r_memren  <= w_memren;
      r_memwren <= w_memwren;
      r_wbsel   <= w_wbsel;
      r_alusel  <= w_alusel;
      r_illegal <= w_illegal;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && !flush_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1'b1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_valid;
  assign pc_o        = r_pc;
  assign insn_o      = r_insn;
  assign rd_o        = r_rd;
  assign rs1_o       = r_rs1;
  assign rs2_o       = r_rs2;
  assign pcsel_o     = r_pcsel;
  assign immsel_o    = r_immsel;
  assign regwren_o   = r_regwren;
  assign rs1sel_o    = r_rs1sel;
  assign rs2sel_o    = r_rs2sel;
  assign memren_o    = r_memren;
  assign memwren_o   = r_memwren;
  assign wbsel_o     = r_wbsel;
  assign alusel_o    = r_alusel;
  assign illegal_o   = r_illegal;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed self-checking bench for ctrl_decode_stage: decode, load-use stall, backpressure, flush, reset.
module tb_ctrl_decode_stage;
  logic        clk, reset;
  logic        in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
  logic [31:0] insn_i, pc_i, pc_o, insn_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic        pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o, illegal_o;
  logic [1:0]  wbsel_o;
  logic [3:0]  alusel_o;
  logic [15:0] stall_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  ctrl_decode_stage dut (
    .clk(clk), .reset(reset), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .insn_i(insn_i), .pc_i(pc_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .pc_o(pc_o), .insn_o(insn_o), .rd_o(rd_o), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .pcsel_o(pcsel_o), .immsel_o(immsel_o), .regwren_o(regwren_o),
    .rs1sel_o(rs1sel_o), .rs2sel_o(rs2sel_o), .memren_o(memren_o), .memwren_o(memwren_o),
    .wbsel_o(wbsel_o), .alusel_o(alusel_o), .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_k(input int k);
    addi_k = (32'(k) << 20) | (32'(k) << 7) | 32'h0000_0013;
  endfunction

  // decode vectors: insn, alusel, regwren, pcsel, wbsel
  logic [31:0] vec_insn [6] = '{32'h00500093, 32'h402083B3, 32'h4021D193,
                                32'h00500013, 32'h008000EF, 32'h12345137};
  logic [3:0]  vec_alu  [6] = '{4'd0, 4'd1, 4'd7, 4'd0, 4'd0, 4'd0};
  logic        vec_wren [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        vec_pcs  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0]  vec_wb   [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3};

  initial begin
    reset = 1'b1; in_valid_i = 1'b0; insn_i = 32'd0; pc_i = 32'd0;
    flush_i = 1'b0; out_ready_i = 1'b1;
    step(); step();
    check_eq("rst_valid", 32'(out_valid_o), 32'd0);
    check_eq("rst_wbsel", 32'(wbsel_o), 32'd0);
    check_eq("rst_alusel", 32'(alusel_o), 32'd0);
    check_eq("rst_stall", 32'(stall_cnt_o), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready_o), 32'd1);
    reset = 1'b0;
    step();

    // 1: addi x1,x0,5
    in_valid_i = 1'b1; insn_i = 32'h00500093; pc_i = 32'h100;
    step();
    in_valid_i = 1'b0;
    check_eq("addi_valid", 32'(out_valid_o), 32'd1);
    check_eq("addi_regwren", 32'(regwren_o), 32'd1);
    check_eq("addi_immsel", 32'(immsel_o), 32'd1);
    check_eq("addi_rs1sel", 32'(rs1sel_o), 32'd1);
    check_eq("addi_alusel", 32'(alusel_o), 32'd0);
    check_eq("addi_wbsel", 32'(wbsel_o), 32'd0);
    check_eq("addi_rd", 32'(rd_o), 32'd1);
    check_eq("addi_pc", pc_o, 32'h100);
    step();
    check_eq("drain_valid", 32'(out_valid_o), 32'd0);
    check_eq("drain_regwren", 32'(regwren_o), 32'd0);

    // 2: load-use stall
    in_valid_i = 1'b1; insn_i = 32'h00012283; pc_i = 32'h200;
    step();
    check_eq("lw_memren", 32'(memren_o), 32'd1);
    check_eq("lw_wbsel", 32'(wbsel_o), 32'd1);
    check_eq("lw_rd", 32'(rd_o), 32'd5);
    insn_i = 32'h00128333; pc_i = 32'h204;
    #1;
    check_eq("hz_in_ready", 32'(in_ready_o), 32'd0);
    step();
    check_eq("bubble_valid", 32'(out_valid_o), 32'd0);
    check_eq("bubble_memren", 32'(memren_o), 32'd0);
    check_eq("stall_cnt1", 32'(stall_cnt_o), 32'd1);
    check_eq("post_in_ready", 32'(in_ready_o), 32'd1);
    step();
    in_valid_i = 1'b0;
    check_eq("add_valid", 32'(out_valid_o), 32'd1);
    check_eq("add_insn", insn_o, 32'h00128333);
    check_eq("add_rs2sel", 32'(rs2sel_o), 32'd1);
    check_eq("add_rd", 32'(rd_o), 32'd6);
    in_valid_i = 1'b1; insn_i = 32'h00012283; pc_i = 32'h300;
    step();
    insn_i = 32'h00120333; pc_i = 32'h304;
    #1;
    check_eq("nohz_in_ready", 32'(in_ready_o), 32'd1);
    step();
    in_valid_i = 1'b0;
    check_eq("nohz_insn", insn_o, 32'h00120333);
    check_eq("nohz_stall", 32'(stall_cnt_o), 32'd1);
    step();

    // 3: backpressure mid-stream
    in_valid_i = 1'b1; insn_i = addi_k(1); pc_i = 32'h400; out_ready_i = 1'b1;
    step();
    insn_i = addi_k(2); pc_i = 32'h404; out_ready_i = 1'b0;
    #1;
    check_eq("bp_in_ready", 32'(in_ready_o), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("bp_frozen_insn", insn_o, addi_k(1));
      check_eq("bp_frozen_valid", 32'(out_valid_o), 32'd1);
    end
    out_ready_i = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      insn_i = addi_k(k); pc_i = 32'h400 + 32'(4 * (k - 1));
      step();
      check_eq("bp_stream_insn", insn_o, addi_k(k));
      check_eq("bp_stream_pc", pc_o, 32'h400 + 32'(4 * (k - 1)));
    end
    in_valid_i = 1'b0;
    step();
    check_eq("bp_end_valid", 32'(out_valid_o), 32'd0);

    // 4: flush drops both register and input
    in_valid_i = 1'b1; insn_i = addi_k(1); pc_i = 32'h500;
    step();
    insn_i = addi_k(2); flush_i = 1'b1; out_ready_i = 1'b0;
    #1;
    check_eq("fl_in_ready", 32'(in_ready_o), 32'd1);
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check_eq("fl_valid", 32'(out_valid_o), 32'd0);
    check_eq("fl_regwren", 32'(regwren_o), 32'd0);
    step();
    check_eq("fl_valid2", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b1;

    // 5: async reset mid-stream
    in_valid_i = 1'b1; insn_i = addi_k(3); pc_i = 32'h600;
    step();
    check_eq("pre_rst_valid", 32'(out_valid_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_valid", 32'(out_valid_o), 32'd0);
    check_eq("arst_stall", 32'(stall_cnt_o), 32'd0);
    check_eq("arst_pc", pc_o, 32'd0);
    in_valid_i = 1'b0;
    step();
    reset = 1'b0;
    step();

    // decode table sweep
    in_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      insn_i = vec_insn[i]; pc_i = 32'h700 + 32'(4 * i);
      step();
      check_eq("vec_alusel", 32'(alusel_o), 32'(vec_alu[i]));
      check_eq("vec_regwren", 32'(regwren_o), 32'(vec_wren[i]));
      check_eq("vec_pcsel", 32'(pcsel_o), 32'(vec_pcs[i]));
      check_eq("vec_wbsel", 32'(wbsel_o), 32'(vec_wb[i]));
    end

    // 6: all-ones instruction
    insn_i = 32'hFFFF_FFFF;
    step();
    in_valid_i = 1'b0;
    check_eq("ill_valid", 32'(out_valid_o), 32'd1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check_eq("ill_flag", 32'(illegal_o), 32'd1);
`else
    check_eq("ill_flag", 32'(illegal_o), 32'd0);
`endif
    check_eq("ill_regwren", 32'(regwren_o), 32'd0);
    check_eq("ill_memwren", 32'(memwren_o), 32'd0);
    check_eq("ill_pcsel", 32'(pcsel_o), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
